multicycle_control_unit: RTL and testbench

Sequential successor to the single-cycle decoder. It holds each RV64I instruction in an internal instruction register and sequences it through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives registered ALU, memory and register-file controls, and handshakes with instruction fetch and data memory. It sits between the fetch unit and the multi-cycle datapath.

---
 rtl/rv_ctrl_pkg.sv | 92 +++++++++
 rtl/rv_decoder.sv | 88 ++++++++
 rtl/multicycle_control_unit.sv | 158 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants, enums and the decoded-control bundle for the
// multi-cycle RV64I control unit.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int ALU_OP_BITS = 5;
    localparam int ALU_IMM_BIT = 5;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_XOR    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_AND    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    localparam logic [1:0] MW_BYTE   = 2'd0;
    localparam logic [1:0] MW_HALF   = 2'd1;
    localparam logic [1:0] MW_WORD   = 2'd2;
    localparam logic [1:0] MW_DOUBLE = 2'd3;

    typedef enum logic [2:0] {
        K_ALU    = 3'd0,
        K_LOAD   = 3'd1,
        K_STORE  = 3'd2,
        K_BRANCH = 3'd3,
        K_JUMP   = 3'd4,
        K_UPPER  = 3'd5
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        alu_op_e    op;
        logic       use_imm;
        logic       word;
        logic       muldiv;
        logic       mem_sign;
        logic [1:0] mem_width;
    } ctrl_t;

    // alt selects sub/sra in the slots shared with add/srl
    function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        unique case (f3)
            3'd0: op = alt ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            3'd7: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational IR -> control bundle decoder with illegal detection.
// RV_MULDIV_EN adds the M-extension encodings (otherwise they are illegal).
module rv_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int REG_WIDTH = 64
) (
    input  logic [31:0] i_ir,
    output ctrl_t       o_ctrl,
    output logic        o_illegal
);

    localparam logic RV32 = (REG_WIDTH == 32);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_unused;

    assign w_opc    = i_ir[6:0];
    assign w_f3     = i_ir[14:12];
    assign w_f7     = i_ir[31:25];
    assign w_unused = ^{i_ir[24:15], i_ir[11:7]};

    always_comb begin
        o_ctrl           = '0;
        o_ctrl.kind      = K_ALU;
        o_ctrl.op        = ALU_ADD;
        o_ctrl.mem_width = w_f3[1:0];
        o_ctrl.mem_sign  = w_f3[2];
        o_illegal        = 1'b0;
        unique case (w_opc)
            OPC_LOAD: begin
                o_ctrl.kind    = K_LOAD;
                o_ctrl.use_imm = 1'b1;
                o_illegal = (w_f3 == 3'd7) ||
                            (RV32 && ((w_f3[1:0] == MW_DOUBLE) ||
                                      (w_f3 == 3'd6)));
            end
            OPC_STORE: begin
                o_ctrl.kind    = K_STORE;
                o_ctrl.use_imm = 1'b1;
                o_illegal = (w_f3 > 3'd3) ||
                            (RV32 && (w_f3 == 3'd3));
            end
            OPC_OP_IMM, OPC_IMM_32: begin
                o_ctrl.use_imm = 1'b1;
                o_ctrl.word    = (w_opc == OPC_IMM_32);
                o_ctrl.op      = alu_f3(w_f3, (w_f3 == 3'd5) & i_ir[30]);
                o_illegal = RV32 && (o_ctrl.word ||
                            (((w_f3 == 3'd1) || (w_f3 == 3'd5)) && i_ir[25]));
            end
            OPC_OP, OPC_OP_32: begin
                o_ctrl.word = (w_opc == OPC_OP_32);
                if (w_f7 == 7'b0000000) begin
                    o_ctrl.op = alu_f3(w_f3, 1'b0);
                end else if ((w_f7 == 7'b0100000) &&
                             ((w_f3 == 3'd0) || (w_f3 == 3'd5))) begin
                    o_ctrl.op = alu_f3(w_f3, 1'b1);
`ifdef RV_MULDIV_EN
                end else if (w_f7 == 7'b0000001) begin
                    o_ctrl.op     = alu_op_e'(5'd10 + {2'b00, w_f3});
                    o_ctrl.muldiv = 1'b1;
`endif
                end else begin
                    o_illegal = 1'b1;
                end
                if (RV32 && o_ctrl.word) begin
                    o_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                o_ctrl.kind = K_BRANCH;
                o_ctrl.op   = ALU_SUB;
            end
            OPC_JAL, OPC_JALR: begin
                o_ctrl.kind    = K_JUMP;
                o_ctrl.use_imm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_ctrl.kind    = K_UPPER;
                o_ctrl.use_imm = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV64I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// RV_MULDIV_EN adds the mul_done port and the M-extension EXECUTE stall.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int REG_WIDTH     = 64,
    parameter int ALU_CTRL_BITS = ALU_IMM_BIT + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    input  logic [31:0]              instruction,
    output logic                     instr_ready,
    input  logic                     mem_ready,
`ifdef RV_MULDIV_EN
    input  logic                     mul_done,
`endif
    output logic [ALU_CTRL_BITS-1:0] ALUCtrl,
    output logic                     alu_word,
    output logic                     branch,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     MemSign,
    output logic [1:0]               MemWidth,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     PCWrite,
    output logic                     IRWrite,
    output logic                     illegal,
    output logic [2:0]               state
);

    if (ALU_CTRL_BITS < 6) begin : g_bad_width
        $error("ALU_CTRL_BITS must be at least 6");
    end

    state_e                   r_state;
    state_e                   w_next;
    logic [31:0]              r_ir;
    ctrl_t                    r_ctrl;
    ctrl_t                    w_ctrl;
    logic                     w_dec_illegal;
    logic                     w_mul_done;
    logic                     w_stall;
    logic [ALU_CTRL_BITS-1:0] w_alu;

    rv_decoder #(
        .REG_WIDTH (REG_WIDTH)
    ) u_dec (
        .i_ir      (r_ir),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_dec_illegal)
    );

`ifdef RV_MULDIV_EN
    assign w_mul_done = mul_done;
`else
    assign w_mul_done = 1'b1;
`endif

    assign w_stall = r_ctrl.muldiv & ~w_mul_done;
    assign state   = r_state;

    always_comb begin
        w_alu                    = '0;
        w_alu[ALU_OP_BITS-1:0]   = r_ctrl.op;
        w_alu[ALU_CTRL_BITS-1]   = r_ctrl.use_imm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            if (IRWrite) begin
                r_ir <= instruction;
            end
            if (r_state == S_DECODE) begin
                r_ctrl <= w_ctrl;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        IRWrite     = 1'b0;
        ALUCtrl     = '0;
        alu_word    = 1'b0;
        branch      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemSign     = 1'b0;
        MemWidth    = 2'd0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        PCWrite     = 1'b0;
        illegal     = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    IRWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_dec_illegal ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                ALUCtrl  = w_alu;
                alu_word = r_ctrl.word;
                unique case (r_ctrl.kind)
                    K_LOAD, K_STORE: w_next = S_MEM;
                    K_BRANCH: begin
                        branch  = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_FETCH;
                    end
                    K_JUMP: begin
                        branch  = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_WRITEBACK;
                    end
                    default: w_next = w_stall ? S_EXECUTE : S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                MemRead  = (r_ctrl.kind == K_LOAD);
                MemWrite = (r_ctrl.kind == K_STORE);
                MemSign  = r_ctrl.mem_sign;
                MemWidth = r_ctrl.mem_width;
                if (mem_ready) begin
                    if (r_ctrl.kind == K_STORE) begin
                        PCWrite = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next  = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                RegWrite = 1'b1;
                MemtoReg = (r_ctrl.kind == K_LOAD);
                // jumps already pulsed PCWrite in EXECUTE
                PCWrite  = (r_ctrl.kind != K_JUMP);
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against a
// cycle-sequence reference model built from the instruction semantics.
module tb_multicycle_control_unit;
    import rv_ctrl_pkg::*;

    localparam int RW = 64;
`ifdef RV_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam int KA = 0;
    localparam int KL = 1;
    localparam int KS = 2;
    localparam int KB = 3;
    localparam int KJ = 4;
    localparam int KU = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;
    logic        mem_ready;
    logic [5:0]  ALUCtrl;
    logic        alu_word;
    logic        branch;
    logic        MemRead;
    logic        MemWrite;
    logic        MemSign;
    logic [1:0]  MemWidth;
    logic        MemtoReg;
    logic        RegWrite;
    logic        PCWrite;
    logic        IRWrite;
    logic        illegal;
    logic [2:0]  state;
`ifdef RV_MULDIV_EN
    logic        mul_done = 1'b1;
`endif

    multicycle_control_unit #(
        .REG_WIDTH     (RW),
        .ALU_CTRL_BITS (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_ready (instr_ready),
        .mem_ready   (mem_ready),
`ifdef RV_MULDIV_EN
        .mul_done    (mul_done),
`endif
        .ALUCtrl     (ALUCtrl),
        .alu_word    (alu_word),
        .branch      (branch),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSign     (MemSign),
        .MemWidth    (MemWidth),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir;
        logic       irw;
        logic [5:0] alu;
        logic       aw;
        logic       br;
        logic       mrd;
        logic       mwr;
        logic       msg;
        logic [1:0] mwd;
        logic       m2r;
        logic       rw;
        logic       pcw;
        logic       ill;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        bit         ill;
        int         kind;
        logic [4:0] op;
        bit         imm;
        bit         word;
        logic [1:0] w;
        bit         sgn;
    } ref_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ir  = instr_ready;
        o.irw = IRWrite;
        o.alu = ALUCtrl;
        o.aw  = alu_word;
        o.br  = branch;
        o.mrd = MemRead;
        o.mwr = MemWrite;
        o.msg = MemSign;
        o.mwd = MemWidth;
        o.m2r = MemtoReg;
        o.rw  = RegWrite;
        o.pcw = PCWrite;
        o.ill = illegal;
        o.st  = state;
        return o;
    endfunction

    function automatic obs_t e_state(input logic [2:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic obs_t e_fetch(input logic iv);
        obs_t o;
        o     = e_state(S_FETCH);
        o.ir  = 1'b1;
        o.irw = iv;
        return o;
    endfunction

    function automatic ref_t ref_dec(input logic [31:0] ins);
        ref_t r;
        int   base [8];
        logic [2:0] f3;
        logic [6:0] f7;
        base = '{0, 5, 8, 9, 2, 6, 3, 4};
        f3 = ins[14:12];
        f7 = ins[31:25];
        r.ill = 0; r.kind = KA; r.op = 5'd0; r.imm = 0;
        r.word = 0; r.w = 2'd0; r.sgn = 0;
        case (ins[6:0])
            7'h03: begin
                r.kind = KL; r.imm = 1; r.w = f3[1:0]; r.sgn = f3[2];
                r.ill = (f3 == 3'd7) ||
                        (RW == 32 && (f3[1:0] == 2'd3 || f3 == 3'd6));
            end
            7'h23: begin
                r.kind = KS; r.imm = 1; r.w = f3[1:0];
                r.ill = (f3 > 3'd3) || (RW == 32 && f3 == 3'd3);
            end
            7'h13, 7'h1B: begin
                r.imm  = 1;
                r.word = ins[3];
                r.op   = 5'(base[f3]);
                if (f3 == 3'd5 && ins[30]) r.op = 5'd7;
                r.ill = (RW == 32) &&
                        (r.word || ((f3 == 3'd1 || f3 == 3'd5) && ins[25]));
            end
            7'h33, 7'h3B: begin
                r.word = ins[3];
                if (f7 == 7'h00) r.op = 5'(base[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) r.op = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) r.op = 5'd7;
                else if (MD && f7 == 7'h01) r.op = 5'(10 + int'(f3));
                else r.ill = 1;
                if (RW == 32 && r.word) r.ill = 1;
            end
            7'h63: begin r.kind = KB; r.op = 5'd1; end
            7'h6F, 7'h67: begin r.kind = KJ; r.imm = 1; end
            7'h37, 7'h17: begin r.kind = KU; r.imm = 1; end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    task automatic cyc(input string tag, input logic iv,
                       input logic [31:0] ins, input logic mr,
                       input logic r, input obs_t e);
        rst         = r;
        instr_valid = iv;
        instruction = ins;
        mem_ready   = mr;
        @(negedge clk);
        chk(tag, {42'd0, sample()}, {42'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic junk(input string tag, input obs_t e);
        cyc(tag, 1'($urandom), $urandom, 1'($urandom), 1'b0, e);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input int waits);
        ref_t r;
        obs_t e;
        r = ref_dec(ins);
        if ($urandom_range(0, 1) == 1)
            cyc({tag, ".idle"}, 1'b0, $urandom, 1'($urandom), 1'b0, e_fetch(1'b0));
        cyc({tag, ".F"}, 1'b1, ins, 1'($urandom), 1'b0, e_fetch(1'b1));
        junk({tag, ".D"}, e_state(S_DECODE));
        if (r.ill) begin
            e     = e_state(S_TRAP);
            e.ill = 1'b1;
            junk({tag, ".T0"}, e);
            junk({tag, ".T1"}, e);
            cyc({tag, ".Trst"}, 1'b0, $urandom, 1'($urandom), 1'b1, e);
            cyc({tag, ".post"}, 1'b0, $urandom, 1'($urandom), 1'b0, e_fetch(1'b0));
            return;
        end
        e     = e_state(S_EXECUTE);
        e.alu = {r.imm, r.op};
        e.aw  = r.word;
        e.br  = (r.kind == KB) || (r.kind == KJ);
        e.pcw = e.br;
        junk({tag, ".EX"}, e);
        if (r.kind == KL || r.kind == KS) begin
            for (int i = 0; i <= waits; i++) begin
                e     = e_state(S_MEM);
                e.mrd = (r.kind == KL);
                e.mwr = (r.kind == KS);
                e.msg = r.sgn;
                e.mwd = r.w;
                e.pcw = (r.kind == KS) && (i == waits);
                cyc($sformatf("%s.M%0d", tag, i), 1'($urandom), $urandom,
                    (i == waits), 1'b0, e);
            end
        end
        if (r.kind != KB && r.kind != KS) begin
            e     = e_state(S_WRITEBACK);
            e.rw  = 1'b1;
            e.m2r = (r.kind == KL);
            e.pcw = (r.kind != KJ);
            junk({tag, ".WB"}, e);
        end
    endtask

    task automatic sw_reset_mid_mem();
        obs_t e;
        cyc("swr.F", 1'b1, 32'h0020A023, 1'b0, 1'b0, e_fetch(1'b1));
        cyc("swr.D", 1'b0, 32'h0, 1'b0, 1'b0, e_state(S_DECODE));
        e     = e_state(S_EXECUTE);
        e.alu = 6'b100000;
        cyc("swr.EX", 1'b0, 32'h0, 1'b0, 1'b0, e);
        e     = e_state(S_MEM);
        e.mwr = 1'b1;
        e.mwd = 2'd2;
        cyc("swr.M0", 1'b0, 32'h0, 1'b0, 1'b0, e);
        cyc("swr.Mrst", 1'b0, 32'h0, 1'b0, 1'b1, e);
        cyc("swr.after", 1'b0, 32'h0, 1'b1, 1'b0, e_fetch(1'b0));
        cyc("swr.late", 1'b0, 32'h0, 1'b1, 1'b0, e_fetch(1'b0));
    endtask

    logic [6:0] opcs [12];

    initial begin
        logic [31:0] ins;
        opcs = '{7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B,
                 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1'b0, 32'h0, 1'b0, 1'b0, e_fetch(1'b0));

        run_instr("add",   32'h002081B3, 0);
        run_instr("ld",    32'h0000B183, 3);
        run_instr("beq",   32'h00208463, 0);
        run_instr("srai",  32'h4030D093, 0);
        run_instr("sraiw", 32'h4030D09B, 0);
        run_instr("sub",   32'h402081B3, 0);
        run_instr("lbu",   32'h0000C183, 0);
        run_instr("sw",    32'h0020A023, 2);
        run_instr("jal",   32'h008000EF, 0);
        run_instr("lui",   32'h000011B7, 0);
        run_instr("mul",   32'h022081B3, 0);
        run_instr("ill7f", 32'h0000007F, 0);
        sw_reset_mid_mem();

        for (int n = 0; n < 400; n++) begin
            ins      = $urandom;
            ins[6:0] = opcs[$urandom_range(0, 11)];
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                2: ins[31:25] = 7'h01;
                default: ;
            endcase
            run_instr($sformatf("rnd%0d_%h", n, ins), ins,
                      int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
